lc3_fetch_agu: RTL
==================

Name: lc3_fetch_agu

Overview:
Parametrised successor to the LC-3 PC/IR/address datapath slice. Owns PC, IR and MAR registers and the ADDR1/ADDR2 effective-address adder, and adds an autonomous instruction-fetch sequencer with a valid/ready memory request port and a separate response port. Sits between the control unit, which drives the selects and load strobes, and the memory interface. Replaces the shared tristate bus with explicit driven outputs.

Parameters:
ADDR_W, 16, width of PC, MAR and effective address
DATA_W, 16, instruction word width; must be >= 11
RESET_PC, 16'h3000, PC value after reset, truncated to ADDR_W
TIMEOUT_CYC, 255, fetch watchdog limit in cycles; used only with FETCH_TIMEOUT_EN

Ports:
clk  in  1  single clock; all state changes on rising edge
rst_n  in  1  asynchronous active-low reset
fetch_start  in  1  request instruction fetch at current PC
fetch_busy  out  1  high while the sequencer is not IDLE
ir_valid  out  1  one-cycle pulse when IR has been loaded by a fetch
ir_out  out  DATA_W  instruction register
mem_req_valid  out  1  fetch read request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_W  request address, equal to MAR
mem_rsp_valid  in  1  read data valid
mem_rsp_data  in  DATA_W  read data
ld_pc  in  1  control-unit PC load
pcmux_sel  in  2  0=PC+1, 1=pc_ext_in, 2=sum, 3=hold
pc_ext_in  in  ADDR_W  external PC source (bus/trap vector)
addr1_sel  in  1  0=PC, 1=base_in
base_in  in  ADDR_W  BaseR value from register file
addr2_sel  in  2  0=zero, 1=sext IR[5:0], 2=sext IR[8:0], 3=sext IR[10:0]
marmux_sel  in  1  0=zero-ext IR[7:0], 1=sum
ld_mar  in  1  control-unit MAR load from MARMUX
pc_out  out  ADDR_W  PC register
mar_out  out  ADDR_W  MAR register
ea_out  out  ADDR_W  combinational MARMUX output
fetch_err  out  1  one-cycle timeout pulse (0 when feature is off)

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, ir=0, mar=0, state=IDLE, mem_req_valid=0, ir_valid=0, fetch_busy=0, fetch_err=0, watchdog=0.
- sum = ADDR1 + ADDR2, computed modulo 2^ADDR_W. Sign-extension and zero-extension go to ADDR_W. ADDR1 source 0 is the PC register, not the PCMUX output. PC+1 wraps from all-ones to 0.
- FSM states: IDLE, REQ, WAIT.
- IDLE with fetch_start=1: at the edge, mar<=pc, pc<=pc+1, go to REQ. ld_pc and ld_mar in the same cycle are ignored because fetch wins.
- REQ: mem_req_valid=1, mem_req_addr=mar, held stable until mem_req_ready. On valid&&ready, go to WAIT. mem_rsp_valid is ignored in REQ.
- WAIT: on mem_rsp_valid, ir<=mem_rsp_data, go to IDLE, and ir_valid=1 in the following cycle only. The earliest next fetch_start is accepted in that cycle.
- fetch_busy = (state != IDLE). While busy: fetch_start, ld_pc and ld_mar are ignored.
- IDLE with no fetch: if ld_pc, pc<=PCMUX. pcmux_sel=3 holds PC. If ld_mar, mar<=MARMUX. Both loads may occur in the same cycle. ea_out always reflects the current MARMUX value.
- Reset asserted mid-fetch: immediately returns to IDLE. Any in-flight response is dropped by the environment.

Optional Feature:
FETCH_TIMEOUT_EN
- With the macro defined: a watchdog counts cycles spent in REQ+WAIT and clears on leaving IDLE. When it reaches TIMEOUT_CYC without completing, the block returns to IDLE, restores pc<=mar so the fetch can be retried, leaves IR unchanged, and pulses fetch_err for one cycle. ir_valid is not asserted.
- Without the macro: no counter is built, fetch_err is tied to 0, and WAIT waits indefinitely.

Decomposition:
- Package lc3_pkg: FSM state enum; PCMUX, ADDR2 and MARMUX select encodings; IR field positions (OFF6, PCOFF9, PCOFF11, TRAPVECT8).
- One sub-module, lc3_agu_comb: purely combinational ADDR1/ADDR2 muxes, sign extension, adder and MARMUX, parametrised by ADDR_W and DATA_W.

Test Plan:
- Reset: hold rst_n=0 -> pc_out=16'h3000, ir_out=0, mar_out=0, fetch_busy=0, mem_req_valid=0.
- Fetch: fetch_start at pc=3000, ready after 2 cycles, response 3 cycles later with 16'h1234 -> mem_req_addr=3000 held stable, pc=3001, ir_out=1234, exactly one ir_valid pulse.
- Branch: ir=16'h0E05 (PCoffset9=5), pc=3001, addr1_sel=0, addr2_sel=2, pcmux_sel=2, ld_pc -> pc=3006. Repeat with IR[8:0]=1FF -> pc=3000.
- Wrap/MARMUX: pc=FFFF, ld_pc with pcmux_sel=0 -> pc=0000. ir=F025, marmux_sel=0, ld_mar -> mar=0025.
- Contention: fetch_start together with ld_pc and ld_mar in IDLE -> fetch proceeds and the control loads are ignored. ld_pc while busy -> PC unchanged.
- With FETCH_TIMEOUT_EN and TIMEOUT_CYC=8: no mem_req_ready -> fetch_err pulses after 8 cycles, pc restored to 3000, back in IDLE, IR unchanged.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared encodings for the LC-3 fetch/AGU slice: sequencer states, datapath
// mux selects and IR immediate-field widths.
package lc3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_e;

  localparam logic [1:0] PCMUX_INC  = 2'd0;
  localparam logic [1:0] PCMUX_EXT  = 2'd1;
  localparam logic [1:0] PCMUX_SUM  = 2'd2;
  localparam logic [1:0] PCMUX_HOLD = 2'd3;

  localparam logic       ADDR1_PC   = 1'b0;
  localparam logic       ADDR1_BASE = 1'b1;

  localparam logic [1:0] ADDR2_ZERO    = 2'd0;
  localparam logic [1:0] ADDR2_OFF6    = 2'd1;
  localparam logic [1:0] ADDR2_PCOFF9  = 2'd2;
  localparam logic [1:0] ADDR2_PCOFF11 = 2'd3;

  localparam logic       MARMUX_TRAP = 1'b0;
  localparam logic       MARMUX_SUM  = 1'b1;

  // IR immediate fields all start at bit 0; only their widths differ.
  localparam int unsigned OFF6_W      = 6;
  localparam int unsigned PCOFF9_W    = 9;
  localparam int unsigned PCOFF11_W   = 11;
  localparam int unsigned TRAPVECT8_W = 8;

endpackage

// File: rtl/lc3_agu_comb.sv
// Combinational effective-address unit: ADDR1/ADDR2 muxes, IR-field sign
// extension, modulo-2^ADDR_W adder and MARMUX.
module lc3_agu_comb
  import lc3_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [DATA_W-1:0] i_ir,
  input  logic              i_addr1_sel,
  input  logic [1:0]        i_addr2_sel,
  input  logic              i_marmux_sel,
  output logic [ADDR_W-1:0] o_sum,
  output logic [ADDR_W-1:0] o_marmux
);

  logic [ADDR_W-1:0] w_addr1;
  logic [ADDR_W-1:0] w_addr2;
  logic [ADDR_W-1:0] w_sum;

  always_comb begin
    w_addr1 = (i_addr1_sel == ADDR1_BASE) ? i_base : i_pc;
    w_addr2 = '0;
    case (i_addr2_sel)
      ADDR2_OFF6:
        w_addr2 = {{(ADDR_W-OFF6_W){i_ir[OFF6_W-1]}}, i_ir[OFF6_W-1:0]};
      ADDR2_PCOFF9:
        w_addr2 = {{(ADDR_W-PCOFF9_W){i_ir[PCOFF9_W-1]}}, i_ir[PCOFF9_W-1:0]};
      ADDR2_PCOFF11:
        w_addr2 = {{(ADDR_W-PCOFF11_W){i_ir[PCOFF11_W-1]}}, i_ir[PCOFF11_W-1:0]};
      default:
        w_addr2 = '0;
    endcase
  end

  assign w_sum    = w_addr1 + w_addr2;
  assign o_sum    = w_sum;
  assign o_marmux = (i_marmux_sel == MARMUX_SUM) ? w_sum
                  : {{(ADDR_W-TRAPVECT8_W){1'b0}}, i_ir[TRAPVECT8_W-1:0]};

endmodule

// File: rtl/lc3_fetch_agu.sv
// LC-3 PC/IR/MAR datapath slice with autonomous instruction-fetch sequencer.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module lc3_fetch_agu
  import lc3_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_start,
  output logic              fetch_busy,
  output logic              ir_valid,
  output logic [DATA_W-1:0] ir_out,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  input  logic              ld_pc,
  input  logic [1:0]        pcmux_sel,
  input  logic [ADDR_W-1:0] pc_ext_in,
  input  logic              addr1_sel,
  input  logic [ADDR_W-1:0] base_in,
  input  logic [1:0]        addr2_sel,
  input  logic              marmux_sel,
  input  logic              ld_mar,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] mar_out,
  output logic [ADDR_W-1:0] ea_out,
  output logic              fetch_err
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_mar;
  logic [DATA_W-1:0] r_ir;
  logic              r_ir_valid;
  logic [ADDR_W-1:0] w_sum;
  logic [ADDR_W-1:0] w_marmux;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_pcmux;
  logic              w_rsp_fire;
  logic              w_timeout;

  lc3_agu_comb #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_agu (
    .i_pc         (r_pc),
    .i_base       (base_in),
    .i_ir         (r_ir),
    .i_addr1_sel  (addr1_sel),
    .i_addr2_sel  (addr2_sel),
    .i_marmux_sel (marmux_sel),
    .o_sum        (w_sum),
    .o_marmux     (w_marmux)
  );

  assign w_pc_inc = r_pc + ADDR_W'(1);

  always_comb begin
    w_pcmux = r_pc;
    case (pcmux_sel)
      PCMUX_INC:  w_pcmux = w_pc_inc;
      PCMUX_EXT:  w_pcmux = pc_ext_in;
      PCMUX_SUM:  w_pcmux = w_sum;
      PCMUX_HOLD: w_pcmux = r_pc;
      default:    w_pcmux = r_pc;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rsp_fire  = 1'b0;
    case (r_state)
      ST_IDLE: if (fetch_start) w_state_nxt = ST_REQ;
      ST_REQ:  if (mem_req_ready) w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (mem_rsp_valid) begin
          w_state_nxt = ST_IDLE;
          w_rsp_fire  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_timeout) w_state_nxt = ST_IDLE;
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] r_wdog;
  logic            r_fetch_err;

  // A response arriving on the limit cycle still completes the fetch.
  assign w_timeout = (r_state != ST_IDLE) && !w_rsp_fire &&
                     (r_wdog == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog      <= '0;
      r_fetch_err <= 1'b0;
    end else begin
      r_fetch_err <= w_timeout;
      if (r_state == ST_IDLE) r_wdog <= '0;
      else                    r_wdog <= r_wdog + WD_W'(1);
    end
  end

  assign fetch_err = r_fetch_err;
`else
  assign w_timeout = 1'b0;
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC[ADDR_W-1:0];
      r_mar      <= '0;
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ir_valid <= w_rsp_fire;
      if (w_rsp_fire) r_ir <= mem_rsp_data;
      // Fetch start takes priority over control-unit loads; loads only in IDLE.
      if (r_state == ST_IDLE) begin
        if (fetch_start) begin
          r_mar <= r_pc;
          r_pc  <= w_pc_inc;
        end else begin
          if (ld_pc)  r_pc  <= w_pcmux;
          if (ld_mar) r_mar <= w_marmux;
        end
      end
      if (w_timeout) r_pc <= r_mar;
    end
  end

  assign fetch_busy    = (r_state != ST_IDLE);
  assign mem_req_valid = (r_state == ST_REQ);
  assign mem_req_addr  = r_mar;
  assign ir_valid      = r_ir_valid;
  assign ir_out        = r_ir;
  assign pc_out        = r_pc;
  assign mar_out       = r_mar;
  assign ea_out        = w_marmux;

endmodule
